// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the IF/DM memory port arbiter
package mem_arb_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_e;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - load/decrement wait counter with zero flag
module mem_wait_counter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic zero
);
   localparam int CNT_W = cnt_width(MEM_LATENCY);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

   logic [CNT_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = LOAD_VAL;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between IF and DM requesters
module mem_port_arbiter #(
   parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
   parameter int DATA_W       = mem_arb_pkg::DATA_W,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_value,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_data
);
   import mem_arb_pkg::*;

   localparam int SC_W = cnt_width(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

   state_e            state_d, state_q;
   grant_e            grant_d, grant_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic              we_d, we_q;
   logic [SC_W-1:0]   starve_d, starve_q;
   logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_d, dm_rdata_q;
   logic              if_ready_d, if_ready_q;
   logic              dm_ready_d, dm_ready_q;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic              pick_dm;

   mem_wait_counter #(
      .MEM_LATENCY(MEM_LATENCY)
   ) u_wait (
      .clock(clock),
      .reset(reset),
      .load (cnt_load),
      .dec  (cnt_dec),
      .zero (cnt_zero)
   );

   // DM wins contention until IF has been passed over STARVE_LIMIT times in a row.
   assign pick_dm = dm_req && !(if_req && (starve_q == SC_MAX));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      starve_d   = starve_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_ready_d = 1'b0;
      dm_ready_d = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               grant_d  = pick_dm ? GNT_DM : GNT_IF;
               addr_d   = pick_dm ? dm_addr : if_addr;
               wdata_d  = pick_dm ? dm_wdata : '0;
               we_d     = pick_dm && dm_we;
               cnt_load = 1'b1;
               state_d  = ST_ACCESS;
               if (pick_dm && if_req) begin
                  starve_d = (starve_q == SC_MAX) ? starve_q : starve_q + SC_W'(1);
               end else begin
                  starve_d = '0;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_zero) begin
               state_d = ST_RESP;
               if (grant_q == GNT_IF) begin
                  if_rdata_d = mem_data;
                  if_ready_d = 1'b1;
               end else begin
                  dm_ready_d = 1'b1;
                  if (!we_q) begin
                     dm_rdata_d = mem_data;
                  end
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= GNT_IF;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_ready_q <= 1'b0;
         dm_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_ready_q <= if_ready_d;
         dm_ready_q <= dm_ready_d;
      end
   end

   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;
   assign if_ready    = if_ready_q;
   assign dm_ready    = dm_ready_q;
   assign mem_address = (state_q == ST_ACCESS) ? addr_q : '0;
   assign mem_value   = (state_q == ST_ACCESS) ? wdata_q : '0;
   // Gated by reset so a store aborted in its strobe cycle never reaches the RAM.
   assign mem_write   = (state_q == ST_ACCESS) && cnt_zero && we_q &&
                        (grant_q == GNT_DM) && !reset;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic        clock = 1'b0;
   logic        reset;

   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata, mem_address, mem_value, mem_data;
   logic        if_ready, dm_ready, mem_write;

   logic        if1_req, dm1_req, dm1_we;
   logic [31:0] if1_addr, dm1_addr, dm1_wdata;
   logic [31:0] if1_rdata, dm1_rdata, mem1_address, mem1_value, mem1_data;
   logic        if1_ready, dm1_ready, mem1_write;

   logic [7:0]  ram0 [0:255];
   logic [7:0]  ram1 [0:255];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(2)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_address(mem_address), .mem_value(mem_value), .mem_write(mem_write),
      .mem_data(mem_data)
   );

   mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(2)) dut1 (
      .clock(clock), .reset(reset),
      .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_ready(if1_ready),
      .dm_req(dm1_req), .dm_we(dm1_we), .dm_addr(dm1_addr), .dm_wdata(dm1_wdata),
      .dm_rdata(dm1_rdata), .dm_ready(dm1_ready),
      .mem_address(mem1_address), .mem_value(mem1_value), .mem_write(mem1_write),
      .mem_data(mem1_data)
   );

   // Big-endian byte-addressed RAM models with combinational read.
   assign mem_data  = {ram0[mem_address[7:0]], ram0[mem_address[7:0] + 8'd1],
                       ram0[mem_address[7:0] + 8'd2], ram0[mem_address[7:0] + 8'd3]};
   assign mem1_data = {ram1[mem1_address[7:0]], ram1[mem1_address[7:0] + 8'd1],
                       ram1[mem1_address[7:0] + 8'd2], ram1[mem1_address[7:0] + 8'd3]};

   always @(posedge clock) begin
      if (mem_write) begin
         ram0[mem_address[7:0]]        = mem_value[31:24];
         ram0[mem_address[7:0] + 8'd1] = mem_value[23:16];
         ram0[mem_address[7:0] + 8'd2] = mem_value[15:8];
         ram0[mem_address[7:0] + 8'd3] = mem_value[7:0];
      end
      if (mem1_write) begin
         ram1[mem1_address[7:0]]        = mem1_value[31:24];
         ram1[mem1_address[7:0] + 8'd1] = mem1_value[23:16];
         ram1[mem1_address[7:0] + 8'd2] = mem1_value[15:8];
         ram1[mem1_address[7:0] + 8'd3] = mem1_value[7:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag, input logic [31:0] exp_dm_rdata);
      check({tag, ".if_rdata"}, if_rdata, 32'h0);
      check({tag, ".if_ready"}, {31'b0, if_ready}, 32'h0);
      check({tag, ".dm_rdata"}, dm_rdata, exp_dm_rdata);
      check({tag, ".dm_ready"}, {31'b0, dm_ready}, 32'h0);
      check({tag, ".mem_address"}, mem_address, 32'h0);
      check({tag, ".mem_value"}, mem_value, 32'h0);
      check({tag, ".mem_write"}, {31'b0, mem_write}, 32'h0);
   endtask

   // One DM access on the MEM_LATENCY=2 instance, starting in an IDLE cycle.
   task automatic dm_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
      int writes = 0;
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = addr;
      dm_wdata = wdata;
      for (int c = 1; c <= 2; c++) begin
         tick();
         check({tag, ".addr"}, mem_address, addr);
         check({tag, ".early_ready"}, {31'b0, dm_ready}, 32'h0);
         if (mem_write) begin
            writes++;
            check({tag, ".wr_cycle"}, c, 2);
            check({tag, ".wr_value"}, mem_value, wdata);
         end
      end
      tick();
      check({tag, ".ready"}, {31'b0, dm_ready}, 32'h1);
      check({tag, ".rdata"}, dm_rdata, exp_rdata);
      check({tag, ".writes"}, writes, we ? 32'd1 : 32'd0);
      dm_req = 1'b0;
      tick();
      check({tag, ".ready_drop"}, {31'b0, dm_ready}, 32'h0);
   endtask

   initial begin
      int          got;
      int          last;
      logic [1:0]  seq [0:5];
      logic [1:0]  exp_seq [0:5];

      for (int i = 0; i < 256; i++) begin
         ram0[i] = 8'h00;
         ram1[i] = 8'h00;
      end
      {ram0[16], ram0[17], ram0[18], ram0[19]} = 32'hDEADBEEF;
      {ram1[16], ram1[17], ram1[18], ram1[19]} = 32'hDEADBEEF;

      reset = 1'b1;
      if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      if1_req = 1'b0; if1_addr = '0; dm1_req = 1'b0; dm1_we = 1'b0; dm1_addr = '0; dm1_wdata = '0;
      tick();
      tick();
      check_idle_outputs("reset", 32'h0);
      reset = 1'b0;

      // IF-only read
      if_req  = 1'b1;
      if_addr = 32'h10;
      #1;
      check("if.idle_addr", mem_address, 32'h0);
      for (int c = 0; c < 2; c++) begin
         tick();
         check("if.addr", mem_address, 32'h10);
         check("if.no_write", {31'b0, mem_write}, 32'h0);
         check("if.early_ready", {31'b0, if_ready}, 32'h0);
      end
      tick();
      check("if.ready", {31'b0, if_ready}, 32'h1);
      check("if.rdata", if_rdata, 32'hDEADBEEF);
      check("if.resp_addr", mem_address, 32'h0);
      if_req = 1'b0;
      tick();
      check("if.ready_drop", {31'b0, if_ready}, 32'h0);
      check("if.rdata_hold", if_rdata, 32'hDEADBEEF);

      // Store then load
      dm_access("st40", 1'b1, 32'h40, 32'h12345678, 32'h0);
      dm_access("ld40", 1'b0, 32'h40, 32'h0, 32'h12345678);

      // Contention: both held continuously
      exp_seq = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      got = 0;
      last = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         tick();
         if (if_ready || dm_ready) begin
            seq[got] = {if_ready & dm_ready, dm_ready};
            if (got > 0) check("cont.gap", c - last, 32'd4);
            if (dm_ready) check("cont.dm_rdata", dm_rdata, 32'h12345678);
            if (if_ready) check("cont.if_rdata", if_rdata, 32'hDEADBEEF);
            last = c;
            got++;
            if (got == 6) begin
               if_req = 1'b0;
               dm_req = 1'b0;
            end
         end
      end
      check("cont.count", got, 32'd6);
      for (int i = 0; i < got; i++) begin
         check($sformatf("cont.grant%0d", i), {30'b0, seq[i]}, {30'b0, exp_seq[i]});
      end
      tick();

      // Reset in the strobe cycle of a store
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hCAFEF00D;
      tick();
      tick();
      reset  = 1'b1;
      dm_req = 1'b0;
      #1;
      check("rst.mem_write", {31'b0, mem_write}, 32'h0);
      check("rst.dm_ready", {31'b0, dm_ready}, 32'h0);
      tick();
      check_idle_outputs("rst.after", 32'h0);
      reset = 1'b0;
      dm_access("rst.reload", 1'b0, 32'h40, 32'h0, 32'h12345678);

      // Address change while pending is ignored
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
      tick();
      check("chg.addr1", mem_address, 32'h10);
      dm_addr = 32'h40;
      tick();
      check("chg.addr2", mem_address, 32'h10);
      tick();
      check("chg.ready", {31'b0, dm_ready}, 32'h1);
      check("chg.rdata", dm_rdata, 32'hDEADBEEF);
      dm_req = 1'b0;
      tick();

      // MEM_LATENCY=1 instance
      if1_req = 1'b1; if1_addr = 32'h10;
      tick();
      check("l1.addr", mem1_address, 32'h10);
      check("l1.early_ready", {31'b0, if1_ready}, 32'h0);
      tick();
      check("l1.ready", {31'b0, if1_ready}, 32'h1);
      check("l1.rdata", if1_rdata, 32'hDEADBEEF);
      if1_req = 1'b0;
      tick();
      check("l1.ready_drop", {31'b0, if1_ready}, 32'h0);
      check("l1.idle_addr", mem1_address, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
